// File: rtl/fp_pair_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : fp_pair_multiplier
// Description : IEEE-754 single-precision multiplier for the byte-serial
//               FP_1/FP_2 register pair. Operands are latched on start and
//               multiplied with an iterative shift-add significand multiplier.
//               The product is normalised and then rounded to nearest even.
//               Denormal inputs are flushed to zero. The result is registered
//               and marked by a one-cycle done pulse.
// Ports       : clk         - clock, rising edge
//               reset       - asynchronous active-low reset
//               i_start     - operand-ready strobe, sampled only in IDLE
//               i_fp_a      - operand A (FP_1)
//               i_fp_b      - operand B (FP_2)
//               o_result    - registered product, held until the next result
//               o_done      - one-cycle pulse when o_result/flags update
//               o_busy      - high whenever the FSM is not IDLE
//               o_overflow  - finite operands rounded to +/-inf
//               o_underflow - nonzero exact product flushed to zero
//               o_invalid   - NaN operand or inf*0
// Revision    : 1.0 - initial release
// ============================================================================
module fp_pair_multiplier #(
  parameter logic [31:0] QNAN_VAL  = 32'h7FC0_0000,
  parameter int          MUL_ITERS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_fp_a,
  input  logic [31:0] i_fp_b,
  output logic [31:0] o_result,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_invalid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MUL   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [4:0] c_last_iter = 5'(MUL_ITERS - 1);

  state_t             r_state;
  state_t             w_next;

  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_mcand;
  logic [23:0]        r_mplier;
  logic [47:0]        r_acc;
  logic [4:0]         r_cnt;
  logic [23:0]        r_mant;
  logic               r_g;
  logic               r_s;
  logic [31:0]        r_result;
  logic               r_overflow;
  logic               r_underflow;
  logic               r_invalid;

  // Operand classification (FTZ: any exp=0 operand counts as zero)
  logic [7:0]         w_ea;
  logic [7:0]         w_eb;
  logic               w_a_zero;
  logic               w_b_zero;
  logic               w_a_inf;
  logic               w_b_inf;
  logic               w_a_nan;
  logic               w_b_nan;
  logic               w_invalid;
  logic               w_any_inf;
  logic               w_any_zero;
  logic               w_special;
  logic [31:0]        w_special_res;
  logic signed [9:0]  w_exp_sum;

  assign w_ea       = r_a[30:23];
  assign w_eb       = r_b[30:23];
  assign w_a_zero   = (w_ea == 8'h00);
  assign w_b_zero   = (w_eb == 8'h00);
  assign w_a_inf    = (w_ea == 8'hFF) && (r_a[22:0] == 23'h0);
  assign w_b_inf    = (w_eb == 8'hFF) && (r_b[22:0] == 23'h0);
  assign w_a_nan    = (w_ea == 8'hFF) && (r_a[22:0] != 23'h0);
  assign w_b_nan    = (w_eb == 8'hFF) && (r_b[22:0] != 23'h0);
  assign w_invalid  = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
  assign w_any_inf  = w_a_inf | w_b_inf;
  assign w_any_zero = w_a_zero | w_b_zero;
  assign w_special  = w_invalid | w_any_inf | w_any_zero;

  always_comb begin
    w_special_res = {r_a[31] ^ r_b[31], 31'h0};
    if (w_invalid) begin
      w_special_res = QNAN_VAL;
    end else if (w_any_inf) begin
      w_special_res = {r_a[31] ^ r_b[31], 8'hFF, 23'h0};
    end
  end

  // Biased exponent sum, kept signed so under/overflow stay visible
  assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

  // One shift-add step: add multiplicand into the upper half, shift right
  logic [24:0]        w_sum;
  assign w_sum = {1'b0, r_acc[47:24]} + (r_mplier[0] ? {1'b0, r_mcand} : 25'd0);

  // Round to nearest even; a carry out of the significand renormalises
  logic               w_inc;
  logic [24:0]        w_mant_sum;
  logic signed [9:0]  w_exp_rnd;
  logic [22:0]        w_frac_fin;
  logic [31:0]        w_round_res;
  logic               w_rnd_ovf;
  logic               w_rnd_unf;

  assign w_inc      = r_g & (r_s | r_mant[0]);
  assign w_mant_sum = {1'b0, r_mant} + {24'd0, w_inc};
  assign w_exp_rnd  = w_mant_sum[24] ? (r_exp + 10'sd1) : r_exp;
  assign w_frac_fin = w_mant_sum[24] ? w_mant_sum[23:1] : w_mant_sum[22:0];
  assign w_rnd_ovf  = (w_exp_rnd >= 10'sd255);
  assign w_rnd_unf  = (w_exp_rnd <= 10'sd0);

  always_comb begin
    w_round_res = {r_sign, w_exp_rnd[7:0], w_frac_fin};
    if (w_rnd_ovf) begin
      w_round_res = {r_sign, 8'hFF, 23'h0};
    end else if (w_rnd_unf) begin
      w_round_res = {r_sign, 31'h0};
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CHECK;
      S_CHECK: w_next = w_special ? S_DONE : S_MUL;
      S_MUL:   if (r_cnt == c_last_iter) w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a         <= 32'h0;
      r_b         <= 32'h0;
      r_sign      <= 1'b0;
      r_exp       <= 10'sd0;
      r_mcand     <= 24'h0;
      r_mplier    <= 24'h0;
      r_acc       <= 48'h0;
      r_cnt       <= 5'd0;
      r_mant      <= 24'h0;
      r_g         <= 1'b0;
      r_s         <= 1'b0;
      r_result    <= 32'h0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_invalid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a <= i_fp_a;
            r_b <= i_fp_b;
          end
        end
        S_CHECK: begin
          r_sign   <= r_a[31] ^ r_b[31];
          r_exp    <= w_exp_sum;
          r_mcand  <= {1'b1, r_a[22:0]};
          r_mplier <= {1'b1, r_b[22:0]};
          r_acc    <= 48'h0;
          r_cnt    <= 5'd0;
          if (w_special) begin
            r_result    <= w_special_res;
            r_invalid   <= w_invalid;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
          end
        end
        S_MUL: begin
          r_acc    <= {w_sum, r_acc[23:1]};
          r_mplier <= {1'b0, r_mplier[23:1]};
          r_cnt    <= r_cnt + 5'd1;
        end
        S_NORM: begin
          if (r_acc[47]) begin
            r_mant <= r_acc[47:24];
            r_g    <= r_acc[23];
            r_s    <= |r_acc[22:0];
            r_exp  <= r_exp + 10'sd1;
          end else begin
            r_mant <= r_acc[46:23];
            r_g    <= r_acc[22];
            r_s    <= |r_acc[21:0];
          end
        end
        S_ROUND: begin
          r_result    <= w_round_res;
          r_overflow  <= w_rnd_ovf;
          r_underflow <= w_rnd_unf & ~w_rnd_ovf;
          r_invalid   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_result    = r_result;
  assign o_done      = (r_state == S_DONE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
  assign o_invalid   = r_invalid;

endmodule
`default_nettype wire
